// File: rtl/t06_lcd1602_driver.sv
`default_nettype none
// ============================================================================
// Module      : t06_lcd1602_driver
// Description : HD44780 16x2 LCD driver, 8-bit write-only. Runs the power-up
//               init sequence once, then refreshes both lines from a
//               per-frame snapshot of the two ASCII rows.
// Revision    : 1.0 - initial release
// ============================================================================
module t06_lcd1602_driver #(
    parameter int TICK_DIV   = 1000,
    parameter int INIT_WAIT  = 200,
    parameter int CLEAR_WAIT = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] row_top,
    input  logic [127:0] row_bot,
    output logic         lcd_en,
    output logic         lcd_rs,
    output logic         lcd_rw,
    output logic [7:0]   lcd_data,
    output logic         init_done,
    output logic         frame_done
);

    localparam int c_tick_w   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_wait_max = (INIT_WAIT > CLEAR_WAIT) ? INIT_WAIT : CLEAR_WAIT;
    localparam int c_wait_w   = (c_wait_max > 1) ? $clog2(c_wait_max) : 1;

    localparam logic [c_tick_w-1:0] c_tick_last = c_tick_w'(TICK_DIV - 1);
    localparam logic [c_wait_w-1:0] c_init_last =
        (INIT_WAIT > 1) ? c_wait_w'(INIT_WAIT - 1) : '0;
    localparam logic [c_wait_w-1:0] c_clr_last =
        (CLEAR_WAIT > 1) ? c_wait_w'(CLEAR_WAIT - 1) : '0;

    localparam logic [2:0] c_st_powerup    = 3'd0;
    localparam logic [2:0] c_st_init       = 3'd1;
    localparam logic [2:0] c_st_clr_wait   = 3'd2;
    localparam logic [2:0] c_st_line1_addr = 3'd3;
    localparam logic [2:0] c_st_line1      = 3'd4;
    localparam logic [2:0] c_st_line2_addr = 3'd5;
    localparam logic [2:0] c_st_line2      = 3'd6;

    localparam logic [7:0] c_cmd_func  = 8'h38;
    localparam logic [7:0] c_cmd_disp  = 8'h0C;
    localparam logic [7:0] c_cmd_entry = 8'h06;
    localparam logic [7:0] c_cmd_clear = 8'h01;
    localparam logic [7:0] c_cmd_line1 = 8'h80;
    localparam logic [7:0] c_cmd_line2 = 8'hC0;
    localparam logic [7:0] c_blank     = 8'h20;

    logic [2:0]          state_q, state_d;
    logic [c_tick_w-1:0] tick_q, tick_d;
    logic [c_wait_w-1:0] wait_q, wait_d;
    logic                phase_q, phase_d;
    logic [3:0]          idx_q, idx_d;
    logic                rs_q, rs_d;
    logic [7:0]          data_q, data_d;
    logic                init_done_q, init_done_d;
    logic                frame_done_q, frame_done_d;
    logic [127:0]        top_q, top_d;
    logic [127:0]        bot_q, bot_d;

    logic                w_tick_end;
    logic [3:0]          w_idx_inc;
    logic                enter_frame;

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        case (i)
            2'd0:    return c_cmd_func;
            2'd1:    return c_cmd_disp;
            2'd2:    return c_cmd_entry;
            default: return c_cmd_clear;
        endcase
    endfunction

    // Char 0 sits in the top byte, so the bit offset is 8*(15-i).
    function automatic logic [7:0] char_at(input logic [127:0] row, input logic [3:0] i);
        return row[{~i, 3'b000} +: 8];
    endfunction

    assign w_tick_end = (tick_q == c_tick_last);
    assign w_idx_inc  = idx_q + 4'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= c_st_powerup;
            tick_q       <= '0;
            wait_q       <= '0;
            phase_q      <= 1'b0;
            idx_q        <= '0;
            rs_q         <= 1'b0;
            data_q       <= '0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            top_q        <= {16{c_blank}};
            bot_q        <= {16{c_blank}};
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            wait_q       <= wait_d;
            phase_q      <= phase_d;
            idx_q        <= idx_d;
            rs_q         <= rs_d;
            data_q       <= data_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
            top_q        <= top_d;
            bot_q        <= bot_d;
        end
    end

    // All state movement happens on tick boundaries; rs/data are loaded as a
    // step is entered so they are stable for the whole enable pulse.
    always_comb begin
        state_d      = state_q;
        tick_d       = tick_q + c_tick_w'(1);
        wait_d       = wait_q;
        phase_d      = phase_q;
        idx_d        = idx_q;
        rs_d         = rs_q;
        data_d       = data_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;
        top_d        = top_q;
        bot_d        = bot_q;
        enter_frame  = 1'b0;

        if (w_tick_end) begin
            tick_d = '0;
            case (state_q)
                c_st_powerup: begin
                    if (wait_q == c_init_last) begin
                        state_d = c_st_init;
                        wait_d  = '0;
                        idx_d   = '0;
                        phase_d = 1'b0;
                        rs_d    = 1'b0;
                        data_d  = c_cmd_func;
                    end else begin
                        wait_d = wait_q + c_wait_w'(1);
                    end
                end
                c_st_clr_wait: begin
                    if (wait_q == c_clr_last) begin
                        enter_frame = 1'b1;
                    end else begin
                        wait_d = wait_q + c_wait_w'(1);
                    end
                end
                default: begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        case (state_q)
                            c_st_init: begin
                                if (idx_q == 4'd3) begin
                                    if (CLEAR_WAIT == 0) begin
                                        enter_frame = 1'b1;
                                    end else begin
                                        state_d = c_st_clr_wait;
                                        wait_d  = '0;
                                    end
                                end else begin
                                    idx_d  = w_idx_inc;
                                    data_d = init_cmd(w_idx_inc[1:0]);
                                end
                            end
                            c_st_line1_addr: begin
                                state_d = c_st_line1;
                                idx_d   = '0;
                                rs_d    = 1'b1;
                                data_d  = char_at(top_q, 4'd0);
                            end
                            c_st_line1: begin
                                idx_d = w_idx_inc;
                                if (idx_q == 4'd15) begin
                                    state_d = c_st_line2_addr;
                                    rs_d    = 1'b0;
                                    data_d  = c_cmd_line2;
                                end else begin
                                    data_d = char_at(top_q, w_idx_inc);
                                end
                            end
                            c_st_line2_addr: begin
                                state_d = c_st_line2;
                                idx_d   = '0;
                                rs_d    = 1'b1;
                                data_d  = char_at(bot_q, 4'd0);
                            end
                            c_st_line2: begin
                                idx_d = w_idx_inc;
                                if (idx_q == 4'd15) begin
                                    enter_frame  = 1'b1;
                                    frame_done_d = 1'b1;
                                end else begin
                                    data_d = char_at(bot_q, w_idx_inc);
                                end
                            end
                            default: begin
                                state_d = c_st_powerup;
                                wait_d  = '0;
                            end
                        endcase
                    end
                end
            endcase
        end

        // Snapshot both rows exactly once per frame, as line 1 addressing starts.
        if (enter_frame) begin
            state_d     = c_st_line1_addr;
            phase_d     = 1'b0;
            idx_d       = '0;
            rs_d        = 1'b0;
            data_d      = c_cmd_line1;
            top_d       = row_top;
            bot_d       = row_bot;
            init_done_d = 1'b1;
        end
    end

    always_comb begin
        lcd_en = 1'b0;
        case (state_q)
            c_st_init, c_st_line1_addr, c_st_line1,
            c_st_line2_addr, c_st_line2: lcd_en = ~phase_q;
            default:                     lcd_en = 1'b0;
        endcase
        lcd_rs     = rs_q;
        lcd_rw     = 1'b0;
        lcd_data   = data_q;
        init_done  = init_done_q;
        frame_done = frame_done_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_t06_lcd1602_driver.sv
`default_nettype none
// Testbench for t06_lcd1602_driver: scoreboard of expected LCD steps with
// their start cycles, checked on each enable rising edge.
module tb_t06_lcd1602_driver;

    localparam int TICK_DIV   = 2;
    localparam int INIT_WAIT  = 4;
    localparam int CLEAR_WAIT = 3;
    localparam int STEP       = 2 * TICK_DIV;
    localparam int FRAME      = 34 * STEP;
    localparam int FIRST_L1   = (INIT_WAIT + 8 + CLEAR_WAIT) * TICK_DIV;

    logic         clk;
    logic         rst;
    logic [127:0] row_top;
    logic [127:0] row_bot;
    logic         lcd_en;
    logic         lcd_rs;
    logic         lcd_rw;
    logic [7:0]   lcd_data;
    logic         init_done;
    logic         frame_done;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         start;
    } step_t;

    step_t sb[$];
    int    n_total = 0;
    int    n_bad   = 0;
    int    cyc     = 0;
    int    en_run  = 0;
    int    fd_cnt  = 0;
    int    exp_fd  = 0;
    logic  prev_en = 1'b0;

    t06_lcd1602_driver #(
        .TICK_DIV  (TICK_DIV),
        .INIT_WAIT (INIT_WAIT),
        .CLEAR_WAIT(CLEAR_WAIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row_top   (row_top),
        .row_bot   (row_bot),
        .lcd_en    (lcd_en),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_data  (lcd_data),
        .init_done (init_done),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [127:0] make_row(input string s);
        logic [127:0] r;
        r = {16{8'h20}};
        for (int i = 0; i < 16; i++) begin
            if (i < s.len()) r[127-8*i -: 8] = s[i];
        end
        return r;
    endfunction

    task automatic push_step(input logic rs, input logic [7:0] data, input int start);
        step_t e;
        e.rs    = rs;
        e.data  = data;
        e.start = start;
        sb.push_back(e);
    endtask

    task automatic push_init();
        push_step(1'b0, 8'h38, INIT_WAIT * TICK_DIV);
        push_step(1'b0, 8'h0C, INIT_WAIT * TICK_DIV + STEP);
        push_step(1'b0, 8'h06, INIT_WAIT * TICK_DIV + 2 * STEP);
        push_step(1'b0, 8'h01, INIT_WAIT * TICK_DIV + 3 * STEP);
    endtask

    task automatic push_frame(input logic [127:0] top, input logic [127:0] bot, input int start);
        push_step(1'b0, 8'h80, start);
        for (int i = 0; i < 16; i++) push_step(1'b1, top[127-8*i -: 8], start + STEP * (1 + i));
        push_step(1'b0, 8'hC0, start + 17 * STEP);
        for (int i = 0; i < 16; i++) push_step(1'b1, bot[127-8*i -: 8], start + STEP * (18 + i));
    endtask

    task automatic wait_cyc(input int target);
        int budget;
        budget = 4000;
        while (cyc < target && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (cyc < target) chk("timeout_cyc", cyc, target);
    endtask

    task automatic wait_fd(input int target);
        int budget;
        budget = 4000;
        while (fd_cnt < target && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (fd_cnt < target) chk("timeout_frame_done", fd_cnt, target);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            cyc     = 0;
            en_run  = 0;
            prev_en = 1'b0;
        end else begin
            step_t e;
            chk("lcd_rw", 32'(lcd_rw), 0);
            if (lcd_en && !prev_en) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", sb.size(), 1);
                end else begin
                    e = sb.pop_front();
                    chk("step_start", cyc, e.start);
                    chk("step_rs", 32'(lcd_rs), 32'(e.rs));
                    chk("step_data", 32'(lcd_data), 32'(e.data));
                end
            end
            if (lcd_en) begin
                en_run++;
            end else begin
                if (prev_en) chk("en_width", en_run, TICK_DIV);
                en_run = 0;
            end
            if (frame_done) begin
                chk("frame_done_cyc", cyc, exp_fd);
                exp_fd += FRAME;
                fd_cnt++;
            end
            if (cyc == FIRST_L1 - 1) chk("init_done_before", 32'(init_done), 0);
            if (cyc == FIRST_L1)     chk("init_done_after", 32'(init_done), 1);
            prev_en = lcd_en;
            cyc++;
        end
    end

    initial begin
        logic found;
        rst     = 1'b1;
        row_top = make_row("RUN");
        row_bot = {16{8'h41}};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_en", 32'(lcd_en), 0);
        chk("rst_rs", 32'(lcd_rs), 0);
        chk("rst_data", 32'(lcd_data), 0);
        chk("rst_init_done", 32'(init_done), 0);
        chk("rst_frame_done", 32'(frame_done), 0);

        push_init();
        push_frame(row_top, row_bot, FIRST_L1);
        exp_fd = FIRST_L1 + FRAME;
        @(posedge clk);
        #2 rst = 1'b0;

        // Change line 1 while line 2 of frame 0 is being written.
        wait_cyc(FIRST_L1 + 20 * STEP);
        row_top = make_row("PAUSE");
        push_frame(row_top, row_bot, FIRST_L1 + FRAME);
        push_frame(row_top, row_bot, FIRST_L1 + 2 * FRAME);
        push_frame(row_top, row_bot, FIRST_L1 + 3 * FRAME);
        wait_fd(3);

        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk);
            #1;
            if (lcd_en && lcd_rs) found = 1'b1;
        end
        chk("line1_en_seen", {31'b0, found}, 1);
        rst = 1'b1;
        #1;
        chk("midrst_en", 32'(lcd_en), 0);
        chk("midrst_init_done", 32'(init_done), 0);
        chk("midrst_frame_done", 32'(frame_done), 0);
        chk("midrst_data", 32'(lcd_data), 0);

        sb.delete();
        fd_cnt = 0;
        exp_fd = FIRST_L1 + FRAME;
        push_init();
        push_frame(row_top, row_bot, FIRST_L1);
        push_frame(row_top, row_bot, FIRST_L1 + FRAME);
        @(posedge clk);
        #2 rst = 1'b0;
        wait_fd(1);
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", n_bad);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
